// File: rtl/hazard_pkg.sv
//==============================================================================
// Module      : hazard_pkg
// Description : Shared types and default sizes for the hazard control unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package hazard_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_CNT_W  = 32;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
//==============================================================================
// Module      : hazard_scoreboard
// Description : Pending-writeback bits for long-latency ops, with lookups.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    output logic              rs1_pend,
    output logic              rs2_pend,
    output logic              rd_pend,
    output logic              pending_any
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [NREG-1:0] c_live_mask = {{(NREG-1){1'b1}}, 1'b0};

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_set_hit;
    logic [NREG-1:0] w_clr_hit;
    logic [NREG-1:0] w_visible;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
        assign w_set_hit[gi] = set_en && (set_addr == ADDR_W'(gi));
        assign w_clr_hit[gi] = clr_en && (clr_addr == ADDR_W'(gi));
    end

    // Set is applied after clear so a same-cycle issue keeps the bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= ((r_pending & ~w_clr_hit) | w_set_hit) & c_live_mask;
        end
    end

    // Writeback this cycle is visible to decode (register-file write-through).
    assign w_visible   = r_pending & ~w_clr_hit;
    assign rs1_pend    = w_visible[rs1];
    assign rs2_pend    = w_visible[rs2];
    assign rd_pend     = w_visible[rd];
    assign pending_any = |r_pending;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//==============================================================================
// Module      : hazard_ctrl
// Description : Forwarding, stall/flush priority and perf counters for RV32I.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1D,
    input  logic [ADDR_W-1:0] rs2D,
    input  logic [ADDR_W-1:0] rdD,
    input  logic              regWriteD,
    input  logic [ADDR_W-1:0] rs1E,
    input  logic [ADDR_W-1:0] rs2E,
    input  logic [ADDR_W-1:0] rdE,
    input  logic              memReadE,
    input  logic              longIssueE,
    input  logic              pcsrcE,
    input  logic [ADDR_W-1:0] rdM,
    input  logic [ADDR_W-1:0] rdW,
    input  logic              regWriteM,
    input  logic              regWriteW,
    input  logic              longDoneW,
    input  logic [ADDR_W-1:0] longRdW,
    input  logic              icacheStall,
    input  logic              dcacheStall,
    input  logic              ctrClear,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushW,
    output logic              pendingAny,
    output logic [CNT_W-1:0]  cntHazStall,
    output logic [CNT_W-1:0]  cntLoadUse,
    output logic [CNT_W-1:0]  cntFlush,
    output logic [CNT_W-1:0]  cntDcache
);

    logic w_rs1_pend, w_rs2_pend, w_rd_pend, w_any;
    logic w_set_en, w_e_hits_d, w_lu_haz, w_sb_haz;
    logic w_take_haz, w_take_flush;
    fwd_sel_e w_fwd_a, w_fwd_b;

    function automatic fwd_sel_e pick_fwd(
        input logic [ADDR_W-1:0] rs,
        input logic [ADDR_W-1:0] rd_m,
        input logic              we_m,
        input logic [ADDR_W-1:0] rd_w,
        input logic              we_w
    );
        if (we_m && rd_m != '0 && rd_m == rs)      return FWD_M;
        else if (we_w && rd_w != '0 && rd_w == rs) return FWD_W;
        else                                       return FWD_RF;
    endfunction

    assign w_set_en = longIssueE && !stallE && (rdE != '0);

    hazard_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (w_set_en),
        .set_addr   (rdE),
        .clr_en     (longDoneW),
        .clr_addr   (longRdW),
        .rs1        (rs1D),
        .rs2        (rs2D),
        .rd         (rdD),
        .rs1_pend   (w_rs1_pend),
        .rs2_pend   (w_rs2_pend),
        .rd_pend    (w_rd_pend),
        .pending_any(w_any)
    );

    assign w_e_hits_d = (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
    assign w_lu_haz   = memReadE && w_e_hits_d;
    assign w_sb_haz   = (w_rs1_pend && rs1D != '0) || (w_rs2_pend && rs2D != '0) ||
                        (regWriteD && w_rd_pend) || (longIssueE && w_e_hits_d);

    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (rst_n) begin
            w_fwd_a = pick_fwd(rs1E, rdM, regWriteM, rdW, regWriteW);
            w_fwd_b = pick_fwd(rs2E, rdM, regWriteM, rdW, regWriteW);
        end
    end

    assign forwardAE  = w_fwd_a;
    assign forwardBE  = w_fwd_b;
    assign pendingAny = rst_n && w_any;

    // Branch redirect sits above decode stalls so it can never be held off.
    always_comb begin
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        stallM       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        flushW       = 1'b0;
        w_take_haz   = 1'b0;
        w_take_flush = 1'b0;
        if (!rst_n) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushW = 1'b1;
        end else if (dcacheStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (pcsrcE) begin
            flushD       = 1'b1;
            flushE       = 1'b1;
            w_take_flush = 1'b1;
        end else if (w_lu_haz || w_sb_haz) begin
            stallF     = 1'b1;
            stallD     = 1'b1;
            flushE     = 1'b1;
            w_take_haz = 1'b1;
        end else if (icacheStall) begin
            stallF = 1'b1;
            flushD = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || ctrClear)                   cntHazStall <= '0;
        else if (w_take_haz && cntHazStall != '1) cntHazStall <= cntHazStall + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || ctrClear)                              cntLoadUse <= '0;
        else if (w_take_haz && w_lu_haz && cntLoadUse != '1) cntLoadUse <= cntLoadUse + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || ctrClear)                  cntFlush <= '0;
        else if (w_take_flush && cntFlush != '1) cntFlush <= cntFlush + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || ctrClear)                  cntDcache <= '0;
        else if (dcacheStall && cntDcache != '1) cntDcache <= cntDcache + CNT_W'(1);
    end

endmodule

`default_nettype wire
